// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_pkg
// Shared types and constants for the BCD conversion / seven-segment display
// path.
//   conv_state_t : converter FSM states (IDLE, SHIFT, DONE)
//   SEG_*        : active-low glyphs, bit order {dp,g,f,e,d,c,b,a}, dp off
//   bcd_to_seg() : BCD digit to glyph; codes 10-15 map to a blank digit
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] glyph;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bcd_display_ctrl_sseg_digit_scan.sv
// ---------------------------------------------------------------------------
// sseg_digit_scan
// Multiplexed common-anode seven-segment scanner. Each digit is lit for
// REFRESH_DIV clocks, digits scanned 0 (rightmost) upwards, wrapping.
//   clk, rst  : clock, synchronous active-high reset
//   bcd       : packed BCD to show, digit 0 at [3:0]
//   overflow  : show a dash on every digit
//   an        : digit enables, active low, registered
//   seg       : segments {dp,g,f,e,d,c,b,a}, active low, registered with an
// Optional macro LEAD_ZERO_BLANK_EN: blank zero digits above the most
// significant non-zero digit (digit 0 always shown; dashes win).
// ---------------------------------------------------------------------------
module sseg_digit_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  overflow,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  refresh_cnt_reg, refresh_cnt_next;
  logic [IDX_W-1:0]  digit_idx_reg, digit_idx_next;
  logic [DIGITS-1:0] an_reg, an_next;
  logic [7:0]        seg_reg, seg_next;

  logic [3:0]        digit_val [DIGITS];
  logic [DIGITS-1:0] digit_lit;  // 0 = digit is a blanked leading zero

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_val[gi] = bcd[4*gi +: 4];
`ifdef LEAD_ZERO_BLANK_EN
      // A digit stays lit if it or any digit above it is non-zero.
      if (gi == 0) begin : g_ones
        assign digit_lit[gi] = 1'b1;
      end else begin : g_upper
        assign digit_lit[gi] = |bcd[4*DIGITS-1 : 4*gi];
      end
`else
      assign digit_lit[gi] = 1'b1;
`endif
    end
  endgenerate

  always_comb begin
    refresh_cnt_next = refresh_cnt_reg + 1'b1;
    digit_idx_next   = digit_idx_reg;
    if (refresh_cnt_reg == CNT_LAST) begin
      refresh_cnt_next = '0;
      digit_idx_next   = (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
    end

    // an and seg are both derived from the same index and registered
    // together, so they change on the same edge.
    an_next = ~(DIGITS'(1) << digit_idx_reg);
    if (overflow) begin
      seg_next = SEG_DASH;
    end else if (!digit_lit[digit_idx_reg]) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = bcd_to_seg(digit_val[digit_idx_reg]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= '0;
      an_reg          <= '1;
      seg_reg         <= SEG_BLANK;
    end else begin
      refresh_cnt_reg <= refresh_cnt_next;
      digit_idx_reg   <= digit_idx_next;
      an_reg          <= an_next;
      seg_reg         <= seg_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: rtl/bcd_display_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_display_ctrl
// Binary-to-BCD converter (sequential double dabble, one bit per clock)
// feeding a multiplexed seven-segment display.
//   clk, rst   : clock, synchronous active-high reset
//   bin_valid  : bin_in valid
//   bin_in     : unsigned value to convert (BIN_W bits)
//   bin_ready  : converter idle; accepted on bin_valid && bin_ready
//   bcd_out    : last completed result, digit 0 at [3:0]
//   bcd_rdy    : one-cycle pulse when bcd_out/overflow update
//   overflow   : last value exceeded 10^DIGITS-1
//   an, seg    : display drive, active low (see sseg_digit_scan)
// Optional macro LEAD_ZERO_BLANK_EN: leading-zero blanking on the display.
// ---------------------------------------------------------------------------
module bcd_display_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W       = 12,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bin_valid,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  bin_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_rdy,
  output logic                  overflow,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int BCNT_W = $clog2(BIN_W + 1);

  conv_state_t       state_reg, state_next;
  logic [BIN_W-1:0]  shift_reg, shift_next;
  logic [BCD_W-1:0]  scratch_reg, scratch_next;
  logic              ovf_scratch_reg, ovf_scratch_next;
  logic [BCNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [BCD_W-1:0]  bcd_out_reg, bcd_out_next;
  logic              overflow_reg, overflow_next;
  logic              bcd_rdy_reg, bcd_rdy_next;

  // Double-dabble correction: every digit >= 5 gets +3 before the shift so
  // that the shift carries correctly into the next decimal digit.
  logic [BCD_W-1:0]  scratch_adj;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                    ? scratch_reg[4*gi +: 4] + 4'd3
                                    : scratch_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    scratch_next     = scratch_reg;
    ovf_scratch_next = ovf_scratch_reg;
    bit_cnt_next     = bit_cnt_reg;
    bcd_out_next     = bcd_out_reg;
    overflow_next    = overflow_reg;
    bcd_rdy_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bin_valid) begin
          shift_next       = bin_in;
          scratch_next     = '0;
          ovf_scratch_next = 1'b0;
          bit_cnt_next     = BCNT_W'(BIN_W);
          state_next       = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, shift_next} = {scratch_adj[BCD_W-2:0], shift_reg, 1'b0};
        // Any bit carried out of the top digit means the value does not fit.
        ovf_scratch_next = ovf_scratch_reg | scratch_adj[BCD_W-1];
        bit_cnt_next     = bit_cnt_reg - 1'b1;
        if (bit_cnt_reg == BCNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bcd_out_next  = scratch_reg;
        overflow_next = ovf_scratch_reg;
        bcd_rdy_next  = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      scratch_reg     <= '0;
      ovf_scratch_reg <= 1'b0;
      bit_cnt_reg     <= '0;
      bcd_out_reg     <= '0;
      overflow_reg    <= 1'b0;
      bcd_rdy_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      scratch_reg     <= scratch_next;
      ovf_scratch_reg <= ovf_scratch_next;
      bit_cnt_reg     <= bit_cnt_next;
      bcd_out_reg     <= bcd_out_next;
      overflow_reg    <= overflow_next;
      bcd_rdy_reg     <= bcd_rdy_next;
    end
  end

  assign bin_ready = (state_reg == IDLE);
  assign bcd_out   = bcd_out_reg;
  assign overflow  = overflow_reg;
  assign bcd_rdy   = bcd_rdy_reg;

  // bcd_out only changes in DONE, so the display never shows a partial value.
  sseg_digit_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .bcd      (bcd_out_reg),
    .overflow (overflow_reg),
    .an       (an),
    .seg      (seg)
  );

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_ctrl
// Self-checking bench: table of {value, expected BCD, expected overflow},
// a result scoreboard popped on bcd_rdy, and hand-written sequences for
// latency, scan order, held-valid handshakes and reset mid-conversion.
// ---------------------------------------------------------------------------
module tb_bcd_display_ctrl;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int RDIV    = 4;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int PERIOD  = BIN_W + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              bin_valid;
  logic [BIN_W-1:0]  bin_in;
  logic              bin_ready;
  logic [BCD_W-1:0]  bcd_out;
  logic              bcd_rdy;
  logic              overflow;
  logic [DIGITS-1:0] an;
  logic [7:0]        seg;

  always #5 clk = ~clk;

  bcd_display_ctrl #(
    .BIN_W       (BIN_W),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_valid (bin_valid),
    .bin_in    (bin_in),
    .bin_ready (bin_ready),
    .bcd_out   (bcd_out),
    .bcd_rdy   (bcd_rdy),
    .overflow  (overflow),
    .an        (an),
    .seg       (seg)
  );

  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             ovf;
  } exp_t;

  typedef struct {
    int               value;
    logic [BCD_W-1:0] bcd;
    logic             ovf;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BCD_W-1:0] model_bcd(input int v);
    logic [BCD_W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v);
    int lim;
    lim = 1;
    for (int d = 0; d < DIGITS; d++) lim = lim * 10;
    return (v >= lim);
  endfunction

  function automatic logic [7:0] tb_glyph(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [BCD_W-1:0] b, input logic ovf, input int d);
    if (ovf) return 8'hBF;
`ifdef LEAD_ZERO_BLANK_EN
    if (d > 0 && (b >> (4 * d)) == '0) return 8'hFF;
`endif
    return tb_glyph(b[4*d +: 4]);
  endfunction

  // Result monitor: one line per completed conversion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bcd_rdy === 1'b1) begin
      rdy_seen++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bcd_rdy: got bcd_out=0x%0h, want no pulse", bcd_out);
      end else begin
        e = sb_q.pop_front();
        $display("conv: bcd_out=0x%04h overflow=%0b (expected 0x%04h/%0b)", bcd_out, overflow, e.bcd, e.ovf);
        check("conv_bcd", 32'(bcd_out), 32'(e.bcd));
        check("conv_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  // Drive one value at a negedge once the converter is ready; returns at
  // the negedge following the handshake edge with bin_valid dropped.
  task automatic convert(input int value, input logic push, input exp_t e);
    int n;
    n = 0;
    while (bin_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(bin_ready), 32'd1);
    bin_valid = 1'b1;
    bin_in    = BIN_W'(value);
    if (push) sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bin_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  // Observe several scan rounds; check glyph per digit, one-hot an,
  // RDIV-clock dwell and 0->1->2->3->0 ordering.
  task automatic check_scan(input string tag, input logic [BCD_W-1:0] b, input logic ovf);
    int bad_digit [DIGITS];
    int seen [DIGITS];
    int bad_an, bad_run, bad_order, run, idx, zeros;
    logic started;
    logic [DIGITS-1:0] prev_an;
    bad_an = 0; bad_run = 0; bad_order = 0; run = 0; started = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin bad_digit[d] = 0; seen[d] = 0; end
    @(negedge clk);
    @(negedge clk);
    prev_an = an;
    for (int c = 0; c < 3 * DIGITS * RDIV; c++) begin
      if (c > 0) @(negedge clk);
      zeros = 0; idx = 0;
      for (int d = 0; d < DIGITS; d++) if (an[d] == 1'b0) begin zeros++; idx = d; end
      if (zeros != 1) bad_an++;
      else begin
        seen[idx]++;
        if (seg !== exp_seg(b, ovf, idx)) bad_digit[idx]++;
      end
      if (c > 0 && an != prev_an) begin
        if (started && run != RDIV) bad_run++;
        if (an != {prev_an[DIGITS-2:0], prev_an[DIGITS-1]}) bad_order++;
        started = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev_an = an;
    end
    for (int d = 0; d < DIGITS; d++) begin
      check($sformatf("%s_seg_digit%0d_bad", tag, d), 32'(bad_digit[d]), 32'd0);
      check($sformatf("%s_digit%0d_visited", tag, d), 32'(seen[d] == 3 * RDIV), 32'd1);
    end
    check({tag, "_an_onehot_bad"}, 32'(bad_an), 32'd0);
    check({tag, "_dwell_bad"}, 32'(bad_run), 32'd0);
    check({tag, "_order_bad"}, 32'(bad_order), 32'd0);
  endtask

  initial begin
    vec_t vecs [10];
    exp_t e;
    int ready_low, rdy_j, rdy_cnt, bad_ready, base_seen;
    int vals [3];

    vecs[0] = '{0,     16'h0000, 1'b0};
    vecs[1] = '{7,     16'h0007, 1'b0};
    vecs[2] = '{42,    16'h0042, 1'b0};
    vecs[3] = '{1000,  16'h1000, 1'b0};
    vecs[4] = '{10000, 16'h0000, 1'b1};
    vecs[5] = '{9999,  16'h9999, 1'b0};
    vecs[6] = '{16383, 16'h6383, 1'b1};
    vecs[7] = '{8191,  16'h8191, 1'b0};
    vecs[8] = '{12345, 16'h2345, 1'b1};
    vecs[9] = '{509,   16'h0509, 1'b0};

    rst = 1'b1; bin_valid = 1'b0; bin_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_bcd_out", 32'(bcd_out), 32'd0);
    check("rst_bcd_rdy", 32'(bcd_rdy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_bin_ready", 32'(bin_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("first_an", 32'(an), 32'hE);
    check("first_seg", 32'(seg), 32'hC0);

    // Latency and busy window for 1234
    e = '{16'h1234, 1'b0};
    convert(1234, 1'b1, e);
    ready_low = 0; rdy_j = -1; rdy_cnt = 0;
    for (int j = 0; j <= BIN_W + 3; j++) begin
      if (j > 0) @(negedge clk);
      if (bin_ready === 1'b0) ready_low++;
      if (bcd_rdy === 1'b1) begin rdy_cnt++; if (rdy_j < 0) rdy_j = j; end
    end
    check("lat_ready_low_cycles", 32'(ready_low), 32'(BIN_W + 1));
    check("lat_rdy_position", 32'(rdy_j), 32'(BIN_W + 1));
    check("lat_rdy_pulses", 32'(rdy_cnt), 32'd1);
    wait_drain();
    check_scan("scan1234", 16'h1234, 1'b0);

    // Table-driven conversions with display check after each
    for (int i = 0; i < 10; i++) begin
      e = '{vecs[i].bcd, vecs[i].ovf};
      convert(vecs[i].value, 1'b1, e);
      wait_drain();
      check_scan($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].ovf);
    end

    // bin_valid held high with changing data: only ready cycles accepted
    vals[0] = 321; vals[1] = 9876; vals[2] = 15000;
    base_seen = rdy_seen;
    bad_ready = 0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      bin_valid = 1'b1;
      bin_in    = BIN_W'(vals[k % 3]);
      if (bin_ready !== ((k % PERIOD) == 0)) bad_ready++;
      if ((k % PERIOD) == 0) sb_q.push_back('{model_bcd(vals[k % 3]), model_ovf(vals[k % 3])});
      @(negedge clk);
    end
    bin_valid = 1'b0;
    wait_drain();
    check("held_ready_pattern_bad", 32'(bad_ready), 32'd0);
    check("held_rdy_pulses", 32'(rdy_seen - base_seen), 32'd2);

    // Reset in the 5th SHIFT cycle abandons the conversion
    convert(4321, 1'b0, e);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    bin_valid = 1'b1;
    bin_in = BIN_W'(5);
    @(negedge clk);
    check("midrst_bcd_out", 32'(bcd_out), 32'd0);
    check("midrst_bin_ready", 32'(bin_ready), 32'd1);
    check("midrst_bcd_rdy", 32'(bcd_rdy), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    bin_valid = 1'b0;
    @(negedge clk);
    check("rst_handshake_discarded", 32'(bin_ready), 32'd1);
    base_seen = rdy_seen;
    repeat (BIN_W + 4) @(negedge clk);
    check("midrst_no_pulse", 32'(rdy_seen - base_seen), 32'd0);
    check_scan("after_rst", 16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
